// File: rtl/ctrl_pipe_if.sv
// Host <-> control-unit bundle for the five-stage pipeline: IF/ID instruction and
// branch outcome in, hazard/flush strobes and per-stage control out.
interface ctrl_pipe_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_instr;
  logic             ex_branch_taken;

  logic             stall;
  logic             if_id_flush;
  logic             id_jump;

  logic             ex_reg_dst;
  logic             ex_alu_src;
  logic             ex_branch;
  logic             ex_bne;
  logic [2:0]       ex_alu_op;
  logic [4:0]       ex_write_reg;

  logic             mem_read;
  logic             mem_write;
  logic [4:0]       mem_write_reg;

  logic             wb_reg_write;
  logic             wb_mem_to_reg;
  logic             wb_link;
  logic [4:0]       wb_write_reg;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_instr, ex_branch_taken,
    input  stall, if_id_flush, id_jump,
    input  ex_reg_dst, ex_alu_src, ex_branch, ex_bne, ex_alu_op, ex_write_reg,
    input  mem_read, mem_write, mem_write_reg,
    input  wb_reg_write, wb_mem_to_reg, wb_link, wb_write_reg,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_instr, ex_branch_taken,
    output stall, if_id_flush, id_jump,
    output ex_reg_dst, ex_alu_src, ex_branch, ex_bne, ex_alu_op, ex_write_reg,
    output mem_read, mem_write, mem_write_reg,
    output wb_reg_write, wb_mem_to_reg, wb_link, wb_write_reg,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Pipelined MIPS control: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers,
// load-use stall, branch/jump squash and saturating stall/flush event counters.
module ctrl_pipe #(
  parameter bit EXT_OPS = 1'b1,
  parameter int CNT_W   = 16
) (
  input logic       clk,
  input logic       reset,
  ctrl_pipe_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       bne;
    logic       jump;
    logic       link;
    logic [2:0] alu_op;
  } dec_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       bne;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
    logic [4:0] write_reg;
  } idex_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
    logic [4:0] write_reg;
  } exmem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
    logic [4:0] write_reg;
  } memwb_t;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_instr;

  assign opcode       = bus.id_instr[31:26];
  assign rs           = bus.id_instr[25:21];
  assign rt           = bus.id_instr[20:16];
  assign rd           = bus.id_instr[15:11];
  assign unused_instr = ^bus.id_instr[10:0];

  dec_t       dec;
  logic       uses_rt;
  logic [4:0] id_dest;
  logic       id_reg_write;

  always_comb begin
    dec     = '0;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_FUNCT;
        uses_rt       = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OP_ANDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_AND;
      end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_op    = ALU_ADD;
        uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        uses_rt    = 1'b1;
      end
      OP_BNE: begin
        dec.branch = 1'b1;
        dec.bne    = 1'b1;
        dec.alu_op = ALU_SUB;
        uses_rt    = 1'b1;
      end
      OP_J: dec.jump = 1'b1;
      OP_ORI: if (EXT_OPS) begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_OR;
      end
      OP_SLTI: if (EXT_OPS) begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_SLT;
      end
      OP_JAL: if (EXT_OPS) begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.link      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (dec.reg_dst)   id_dest = rd;
    else if (dec.link) id_dest = 5'd31;
    else               id_dest = rt;
  end

  // Writes to $0 are dropped here so no downstream stage ever sees them.
  assign id_reg_write = dec.reg_write & (id_dest != 5'd0);

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic stall;
  logic id_jump;
  logic flush;
  logic bubble;

  // A taken branch squashes the ID instruction, so it masks both the stall and the jump.
  assign load_use = idex_q.mem_read && (idex_q.write_reg != 5'd0) &&
                    ((idex_q.write_reg == rs) || ((idex_q.write_reg == rt) && uses_rt));
  assign stall    = load_use & ~bus.ex_branch_taken;
  assign id_jump  = dec.jump & ~stall & ~bus.ex_branch_taken;
  assign flush    = bus.ex_branch_taken | id_jump;
  assign bubble   = stall | bus.ex_branch_taken;

  always_comb begin
    idex_d = '0;
    if (!bubble) begin
      idex_d.reg_dst    = dec.reg_dst;
      idex_d.alu_src    = dec.alu_src;
      idex_d.branch     = dec.branch;
      idex_d.bne        = dec.bne;
      idex_d.alu_op     = dec.alu_op;
      idex_d.mem_read   = dec.mem_read;
      idex_d.mem_write  = dec.mem_write;
      idex_d.reg_write  = id_reg_write;
      idex_d.mem_to_reg = dec.mem_to_reg;
      idex_d.link       = dec.link;
      idex_d.write_reg  = id_dest;
    end
  end

  always_comb begin
    exmem_d.mem_read   = idex_q.mem_read;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.link       = idex_q.link;
    exmem_d.write_reg  = idex_q.write_reg;

    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.link       = exmem_q.link;
    memwb_d.write_reg  = exmem_q.write_reg;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall         = stall;
  assign bus.if_id_flush   = flush;
  assign bus.id_jump       = id_jump;

  assign bus.ex_reg_dst    = idex_q.reg_dst;
  assign bus.ex_alu_src    = idex_q.alu_src;
  assign bus.ex_branch     = idex_q.branch;
  assign bus.ex_bne        = idex_q.bne;
  assign bus.ex_alu_op     = idex_q.alu_op;
  assign bus.ex_write_reg  = idex_q.write_reg;

  assign bus.mem_read      = exmem_q.mem_read;
  assign bus.mem_write     = exmem_q.mem_write;
  assign bus.mem_write_reg = exmem_q.write_reg;

  assign bus.wb_reg_write  = memwb_q.reg_write;
  assign bus.wb_mem_to_reg = memwb_q.mem_to_reg;
  assign bus.wb_link       = memwb_q.link;
  assign bus.wb_write_reg  = memwb_q.write_reg;

  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: one DUT with extensions and wide counters, one
// with extensions disabled and 2-bit counters for the saturation case.
module tb_ctrl_pipe;

  localparam logic [31:0] I_NOP      = 32'h0000_0000;
  localparam logic [31:0] I_LW2      = 32'h8C22_0000; // lw  $2,0($1)
  localparam logic [31:0] I_ADD_DEP  = 32'h0044_1820; // add $3,$2,$4
  localparam logic [31:0] I_LW0      = 32'h8C20_0000; // lw  $0,0($1)
  localparam logic [31:0] I_ADD_Z    = 32'h0000_1820; // add $3,$0,$0
  localparam logic [31:0] I_JAL      = 32'h0C00_0010;
  localparam logic [31:0] I_ORI      = 32'h3425_0001; // ori $5,$1,1

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.CNT_W(16)) bus0 ();
  ctrl_pipe_if #(.CNT_W(2))  bus1 ();

  ctrl_pipe #(.EXT_OPS(1'b1), .CNT_W(16)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  ctrl_pipe #(.EXT_OPS(1'b0), .CNT_W(2))  dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus0.id_instr = I_LW2;
    bus0.ex_branch_taken = 1'b0;
    bus1.id_instr = I_NOP;
    bus1.ex_branch_taken = 1'b0;

    tick();
    chk("rst_ex_alu_src", bus0.ex_alu_src, 0);
    chk("rst_ex_write_reg", bus0.ex_write_reg, 0);
    chk("rst_mem_read", bus0.mem_read, 0);
    chk("rst_wb_reg_write", bus0.wb_reg_write, 0);
    chk("rst_stall", bus0.stall, 0);
    chk("rst_flush", bus0.if_id_flush, 0);
    chk("rst_id_jump", bus0.id_jump, 0);
    tick();
    chk("rst_hold_ex_alu_src", bus0.ex_alu_src, 0);
    chk("rst_stall_cnt", bus0.stall_cnt, 0);
    chk("rst_flush_cnt", bus0.flush_cnt, 0);

    reset = 1'b0;
    #1;
    chk("rel_pre_ex_alu_src", bus0.ex_alu_src, 0);
    tick();
    chk("rel_ex_alu_src", bus0.ex_alu_src, 1);
    chk("rel_ex_alu_op", bus0.ex_alu_op, 3'b000);
    chk("rel_ex_write_reg", bus0.ex_write_reg, 2);
    chk("rel_ex_reg_dst", bus0.ex_reg_dst, 0);

    // load-use: lw $2 in EX, dependent add in ID
    bus0.id_instr = I_ADD_DEP;
    #1;
    chk("lu_stall", bus0.stall, 1);
    chk("lu_flush", bus0.if_id_flush, 0);
    tick();
    chk("lu_bubble_write_reg", bus0.ex_write_reg, 0);
    chk("lu_bubble_alu_op", bus0.ex_alu_op, 0);
    chk("lu_bubble_alu_src", bus0.ex_alu_src, 0);
    chk("lu_stall_clear", bus0.stall, 0);
    chk("lu_stall_cnt", bus0.stall_cnt, 1);
    chk("lu_mem_read", bus0.mem_read, 1);
    chk("lu_mem_write_reg", bus0.mem_write_reg, 2);
    tick();
    chk("lu_ex_add_write_reg", bus0.ex_write_reg, 3);
    chk("lu_ex_add_reg_dst", bus0.ex_reg_dst, 1);
    chk("lu_ex_add_alu_op", bus0.ex_alu_op, 3'b010);
    chk("lu_wb_reg_write", bus0.wb_reg_write, 1);
    chk("lu_wb_mem_to_reg", bus0.wb_mem_to_reg, 1);
    chk("lu_wb_write_reg", bus0.wb_write_reg, 2);

    // no false hazard through $0
    bus0.id_instr = I_LW0;
    tick();
    bus0.id_instr = I_ADD_Z;
    #1;
    chk("z_stall", bus0.stall, 0);
    tick();
    chk("z_stall_after", bus0.stall, 0);
    tick();
    chk("z_wb_reg_write", bus0.wb_reg_write, 0);
    chk("z_wb_mem_to_reg", bus0.wb_mem_to_reg, 1);
    chk("z_stall_cnt", bus0.stall_cnt, 1);

    // taken branch overrides pending load-use
    bus0.id_instr = I_LW2;
    tick();
    bus0.id_instr = I_ADD_DEP;
    bus0.ex_branch_taken = 1'b1;
    #1;
    chk("br_stall", bus0.stall, 0);
    chk("br_flush", bus0.if_id_flush, 1);
    chk("br_id_jump", bus0.id_jump, 0);
    tick();
    chk("br_bubble_write_reg", bus0.ex_write_reg, 0);
    chk("br_bubble_alu_op", bus0.ex_alu_op, 0);
    chk("br_flush_cnt", bus0.flush_cnt, 1);
    chk("br_stall_cnt", bus0.stall_cnt, 1);
    bus0.ex_branch_taken = 1'b0;

    // jal with extensions
    bus0.id_instr = I_JAL;
    #1;
    chk("jal_id_jump", bus0.id_jump, 1);
    chk("jal_flush", bus0.if_id_flush, 1);
    tick();
    chk("jal_ex_write_reg", bus0.ex_write_reg, 31);
    bus0.id_instr = I_NOP;
    tick();
    tick();
    chk("jal_wb_reg_write", bus0.wb_reg_write, 1);
    chk("jal_wb_link", bus0.wb_link, 1);
    chk("jal_wb_write_reg", bus0.wb_write_reg, 31);
    chk("jal_flush_cnt", bus0.flush_cnt, 2);

    // reset in the middle of a stall
    bus0.id_instr = I_LW2;
    tick();
    bus0.id_instr = I_ADD_DEP;
    reset = 1'b1;
    #1;
    chk("rst_mid_stall_pre", bus0.stall, 1);
    tick();
    chk("rst_mid_stall_post", bus0.stall, 0);
    chk("rst_mid_stall_cnt", bus0.stall_cnt, 0);
    chk("rst_mid_flush_cnt", bus0.flush_cnt, 0);
    reset = 1'b0;
    bus0.id_instr = I_NOP;
    tick();

    // extensions disabled: jal and ori decode as NOP
    bus1.id_instr = I_JAL;
    #1;
    chk("x0_jal_id_jump", bus1.id_jump, 0);
    chk("x0_jal_flush", bus1.if_id_flush, 0);
    tick();
    chk("x0_jal_ex_write_reg", bus1.ex_write_reg, 0);
    bus1.id_instr = I_ORI;
    tick();
    chk("x0_ori_alu_src", bus1.ex_alu_src, 0);
    chk("x0_ori_alu_op", bus1.ex_alu_op, 0);
    tick();
    chk("x0_jal_wb_reg_write", bus1.wb_reg_write, 0);
    chk("x0_jal_wb_link", bus1.wb_link, 0);
    chk("x0_flush_cnt", bus1.flush_cnt, 0);

    // 2-bit stall counter saturates at 3
    for (int k = 1; k <= 5; k++) begin
      bus1.id_instr = I_LW2;
      tick();
      bus1.id_instr = I_ADD_DEP;
      #1;
      chk($sformatf("sat_stall_%0d", k), bus1.stall, 1);
      tick();
      tick();
      chk($sformatf("sat_cnt_%0d", k), bus1.stall_cnt, (k > 3) ? 3 : k);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
